// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer
// ----------------------
// Command-driven sequencer for a stepper coil-phase driver. A move command
// (step count, direction, post-move dwell) is accepted over a valid/ready
// handshake. The block then emits paced one-cycle step pulses with the
// matching enable/direction levels, tracks a signed absolute position and
// reports completion with a one-cycle done strobe.
//
// Optional feature macro: STEPPER_SOFT_LIMIT_EN
//   defined   : a step that would move position outside [POS_MIN, POS_MAX]
//               is not issued; the move ends at once with limit_hit=1.
//   undefined : no limit check, limit_hit is always 0, position wraps.
//
// Ports
//   clk, rst      sole clock (posedge), synchronous active-high reset
//   cmd_valid     command present
//   cmd_ready     high only while idle
//   cmd_steps     unsigned step count
//   cmd_dir       1 = forward (+1 per step), 0 = reverse
//   cmd_dwell     step periods to hold after the move
//   abort         terminate the active command
//   pos_clr       zero the position (idle only)
//   motor_en      driver enable (high while stepping)
//   motor_dir     driver direction, loaded on accept
//   step_pulse    one-cycle strobe per step
//   busy          command in progress
//   done          one-cycle completion strobe
//   aborted       qualifies done: command was aborted
//   limit_hit     qualifies done: stopped at a soft limit
//   position      signed absolute step count
//
// Handshake: a command is consumed at a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on internal state, never
// on cmd_valid; cmd_valid while busy is simply left pending.
module stepper_move_sequencer #(
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 16,
    parameter int POS_W    = 24,
    parameter int POS_MIN  = -1000,
    parameter int POS_MAX  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_dwell,
    input  logic                    abort,
    input  logic                    pos_clr,
    output logic                    motor_en,
    output logic                    motor_dir,
    output logic                    step_pulse,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    limit_hit,
    output logic signed [POS_W-1:0] position
);

`ifdef STEPPER_SOFT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int                      PRE_W    = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0]        PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic signed [POS_W-1:0] POS_LO   = POS_W'(POS_MIN);
    localparam logic signed [POS_W-1:0] POS_HI   = POS_W'(POS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // state is the FSM observation point for checkers.
    state_t state;
    state_t state_next;

    logic [PRE_W-1:0]        presc;
    logic [CNT_W-1:0]        remaining;
    logic [CNT_W-1:0]        dwell_left;
    logic                    aborted_q;
    logic                    limit_q;
    logic                    tick;
    logic                    stop_abort;
    logic                    beyond;
    logic                    step_now;
    logic                    limit_now;
    logic signed [POS_W-1:0] pos_step;

    assign tick       = (presc == PRE_LAST);
    assign stop_abort = abort && ((state == RUN) || (state == DWELL));
    assign pos_step   = motor_dir ? (position + POS_ONE) : (position - POS_ONE);
    // Position the pending step would reach lies outside the soft window.
    assign beyond     = LIMIT_EN && ((pos_step < POS_LO) || (pos_step > POS_HI));

    always_comb begin
        state_next = state;
        step_now   = 1'b0;
        limit_now  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps != '0)      state_next = RUN;
                    else if (cmd_dwell != '0) state_next = DWELL;
                    else                      state_next = DONE;
                end
            end
            RUN: begin
                // Abort beats a coincident tick: no step is issued.
                if (abort) begin
                    state_next = DONE;
                end else if (tick) begin
                    if (beyond) begin
                        limit_now  = 1'b1;
                        state_next = DONE;
                    end else begin
                        step_now = 1'b1;
                        if (remaining == CNT_W'(1))
                            state_next = (dwell_left != '0) ? DWELL : DONE;
                    end
                end
            end
            DWELL: begin
                if (abort)
                    state_next = DONE;
                else if (tick && (dwell_left == CNT_W'(1)))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            remaining  <= '0;
            dwell_left <= '0;
            motor_dir  <= 1'b0;
            step_pulse <= 1'b0;
            position   <= '0;
            aborted_q  <= 1'b0;
            limit_q    <= 1'b0;
        end else begin
            state      <= state_next;
            step_pulse <= step_now;
            // Both qualifiers are only ever set on the edge entering DONE,
            // so they are high exactly while done is high.
            aborted_q  <= stop_abort;
            limit_q    <= limit_now;
            if (state == IDLE) begin
                presc <= '0;
                if (pos_clr)
                    position <= '0;
                if (cmd_valid) begin
                    remaining  <= cmd_steps;
                    dwell_left <= cmd_dwell;
                    motor_dir  <= cmd_dir;
                end
            end else if ((state == RUN) || (state == DWELL)) begin
                presc <= tick ? '0 : presc + PRE_W'(1);
                if (step_now) begin
                    remaining <= remaining - CNT_W'(1);
                    position  <= pos_step;
                end
                if ((state == DWELL) && tick && !abort)
                    dwell_left <= dwell_left - CNT_W'(1);
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign motor_en  = (state == RUN);
    assign done      = (state == DONE);
    assign aborted   = aborted_q;
    assign limit_hit = limit_q;

endmodule

// File: doc/stepper_move_sequencer.md
# stepper_move_sequencer

Command-driven controller that sequences the stepper driver. It accepts move commands (step count, direction, post-move dwell) over a valid/ready handshake. For each command it generates a paced stream of one-cycle step pulses, plus the enable and direction levels the coil-phase driver consumes. It also tracks absolute signed position and reports completion. It sits between the system-level motion logic and the stepper coil driver, and replaces free-running time-based enable/direction generation.

## Interface
- STEP_DIV, 4: clock cycles per step period and per dwell unit (≥2).
- CNT_W, 16: width of step and dwell counts.
- POS_W, 24: width of signed position.
- POS_MIN, -1000: lower soft limit (used only with the macro).
- POS_MAX, 1000: upper soft limit (used only with the macro).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_steps  in  CNT_W  steps to move, unsigned.
- cmd_dir  in  1  1 = forward (+1 per step), 0 = reverse.
- cmd_dwell  in  CNT_W  step periods to hold after the move.
- abort  in  1  terminate the active command.
- pos_clr  in  1  zero the position; honoured only in IDLE.
- motor_en  out  1  driver enable.
- motor_dir  out  1  driver direction.
- step_pulse  out  1  one-cycle strobe; driver advances one phase.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle completion strobe.
- aborted  out  1  qualifies done: command was aborted.
- limit_hit  out  1  qualifies done: stopped at a soft limit.
- position  out  POS_W  signed absolute step count.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - RUN: motor_en=1, steps emitted.
  - DWELL: motor_en=0, timed hold.
  - DONE: single cycle; done=1.
- Accept:
  - An accept occurs at an edge with cmd_valid && cmd_ready.
  - That edge latches steps, dir and dwell, clears the prescaler and moves to RUN.
  - If steps=0, it goes to DWELL instead; if steps=0 and dwell=0, it goes to DONE.
- Prescaler:
  - Counts 0..STEP_DIV-1 in RUN and DWELL.
  - A tick occurs when it equals STEP_DIV-1; it then wraps to 0.
- RUN tick:
  - step_pulse=1 next cycle.
  - position ±1 per motor_dir.
  - remaining−1.
  - If this was the last step, go to DWELL (dwell>0) or DONE.
- DWELL tick: remaining dwell−1; on the last unit, go to DONE.
- DONE: return to IDLE at the next edge.
- motor_dir:
  - Loads cmd_dir on accept and holds until the next accept.
  - It is stable for the whole RUN, so it never changes in a cycle adjacent to a step_pulse.
- abort:
  - When high in RUN or DWELL, the next edge goes to DONE with aborted=1.
  - Abort in the same cycle as a tick wins: no step and no position change.
  - Ignored in IDLE and DONE.
- cmd_valid while busy is ignored; the command is not consumed.
- pos_clr:
  - In IDLE, position=0 at the next edge.
  - If pos_clr coincides with an accept, the clear applies and the move starts from 0.
- Position wraps two's-complement when the macro is absent.
- Reset:
  - Aborts any activity immediately; no further step_pulse.
  - After reset: state IDLE, cmd_ready=1, motor_en=0, motor_dir=0, step_pulse=0, busy=0, done=0, aborted=0, limit_hit=0, position=0.

## Timing
- Accept edge E0; the first step_pulse is high in the cycle after edge E(STEP_DIV).
- Pulse k is high after edge E(k·STEP_DIV). Pulses are exactly STEP_DIV cycles apart, each exactly one cycle wide.
- position updates on the same edge that raises step_pulse.
- The state leaves RUN on the edge of the last pulse.
- done is high in the cycle after edge E(N·STEP_DIV + M·STEP_DIV). cmd_ready returns one cycle later.
- A zero-length command (steps=0, dwell=0) gives done in the cycle after E0.
- Abort latency is one edge to DONE, so done follows the abort cycle by one cycle.
- Minimum back-to-back accept spacing: command duration + 2 cycles (DONE, IDLE).

## Configuration
- STEPPER_SOFT_LIMIT_EN defined:
  - Before issuing a step, RUN checks whether position ± 1 would leave [POS_MIN, POS_MAX].
  - If it would, no pulse is issued, the position is unchanged, the dwell is skipped, and the block goes directly to DONE with limit_hit=1.
- STEPPER_SOFT_LIMIT_EN undefined:
  - No check is made and limit_hit is constant 0.
  - POS_MIN and POS_MAX are ignored.

## Test plan
- Basic move:
  - Stimulus: STEP_DIV=4; reset; accept steps=3, dir=1, dwell=0.
  - Required: step_pulse after E4, E8 and E12; position 3; done after E12; motor_en low from then on.
- Reverse with dwell:
  - Stimulus: steps=2, dir=0, dwell=2.
  - Required: pulses after E4 and E8; motor_en 0 from E8; done after E16; position −2; busy low the cycle after done.
- Abort:
  - Stimulus: steps=10; assert abort in the tick cycle before edge E12.
  - Required: exactly 2 pulses; position 2; done=1 with aborted=1; cmd_valid held throughout is not accepted until cmd_ready returns.
- Soft limit (macro on):
  - Stimulus: POS_MAX=5, position=4; accept steps=5, dir=1, dwell=3.
  - Required: 1 pulse; position 5; done with limit_hit=1; no dwell.
- Reset and clear:
  - Stimulus: rst mid-RUN.
  - Required: next cycle all outputs at reset values and no further pulses.
  - Stimulus: pos_clr in IDLE after a move.
  - Required: position 0.
  - Stimulus: pos_clr while busy.
  - Required: ignored.
